// File: rtl/twitch_mem_pkg.sv
// Shared types and helpers for the twitch_mem RAM responder:
// access-size encodings, loader states, lane-enable and legality functions.
package twitch_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_COLLECT = 2'd1,
    LD_FLUSH   = 2'd2
  } ld_state_e;

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/twitch_mem_if.sv
// Core-facing bus of twitch_mem: instruction port, data port and byte-stream loader.
// master = core/host side, slave = memory side.
interface twitch_mem_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_data;
  logic [ADDR_W+1:0] d_addr;
  logic [1:0]        d_size;
  logic              d_we;
  logic [31:0]       d_wdata;
  logic [31:0]       d_data;
  logic              d_err;
  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_busy;

  modport master (
    output i_addr, d_addr, d_size, d_we, d_wdata,
    output ld_start, ld_valid, ld_byte, ld_last,
    input  i_data, d_data, d_err, ld_ready, ld_busy
  );

  modport slave (
    input  i_addr, d_addr, d_size, d_we, d_wdata,
    input  ld_start, ld_valid, ld_byte, ld_last,
    output i_data, d_data, d_err, ld_ready, ld_busy
  );
endinterface

// File: rtl/twitch_mem_loader.sv
// Program loader: assembles little-endian stream bytes into words and issues
// full-word write requests to the RAM owner, flushing a zero-padded partial word at the end.
module twitch_mem_loader
  import twitch_mem_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int LOAD_BASE = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be
);

  localparam logic [31:0]       BASE_FULL = LOAD_BASE;
  localparam logic [ADDR_W-1:0] BASE      = BASE_FULL[ADDR_W-1:0];

  ld_state_e         state_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [1:0]        bcnt_r;
  logic [31:0]       shift_r;
  logic              xfer_s;

  assign xfer_s = (state_r == LD_COLLECT) && ld_valid && ld_ready;

  // Write request: a full word on the fourth byte, or the padded partial word in FLUSH.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr_r;
    wr_data = shift_r;
    wr_be   = 4'b1111;
    case (state_r)
      LD_COLLECT: begin
        if (xfer_s && (bcnt_r == 2'd3)) begin
          wr_en   = 1'b1;
          wr_data = {ld_byte, shift_r[23:0]};
        end else begin
          wr_en   = 1'b0;
        end
      end
      LD_FLUSH: wr_en = 1'b1;
      default:  wr_en = 1'b0;
    endcase
  end

  // Loader FSM with byte assembly, word address counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= LD_IDLE;
      waddr_r  <= '0;
      bcnt_r   <= 2'd0;
      shift_r  <= 32'd0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
    end else begin
      case (state_r)
        LD_IDLE: begin
          if (ld_start) begin
            state_r  <= LD_COLLECT;
            waddr_r  <= BASE;
            bcnt_r   <= 2'd0;
            shift_r  <= 32'd0;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
          end
        end
        LD_COLLECT: begin
          if (xfer_s) begin
            if (bcnt_r == 2'd3) begin
              waddr_r <= waddr_r + 1'b1;
              bcnt_r  <= 2'd0;
              shift_r <= 32'd0;
              if (ld_last) begin
                state_r  <= LD_IDLE;
                ld_ready <= 1'b0;
                ld_busy  <= 1'b0;
              end
            end else begin
              shift_r[{bcnt_r, 3'b000} +: 8] <= ld_byte;
              bcnt_r <= bcnt_r + 2'd1;
              if (ld_last) begin
                state_r  <= LD_FLUSH;
                ld_ready <= 1'b0;
              end
            end
          end
        end
        LD_FLUSH: begin
          state_r  <= LD_IDLE;
          waddr_r  <= waddr_r + 1'b1;
          bcnt_r   <= 2'd0;
          shift_r  <= 32'd0;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
        default: begin
          state_r  <= LD_IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/twitch_mem.sv
// Word-organised RAM serving the core's instruction and data ports, filled by
// the byte-stream loader while the core is held off. Reads are read-first.
module twitch_mem
  import twitch_mem_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int LOAD_BASE = 0
) (
  input  logic        clk,
  input  logic        resetn,
  twitch_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       ram [DEPTH];

  logic [ADDR_W-1:0] d_word_s;
  logic [1:0]        d_off_s;
  logic              legal_s;
  logic              ld_ready_s;
  logic              ld_busy_s;
  logic              ld_wr_en_s;
  logic [ADDR_W-1:0] ld_wr_addr_s;
  logic [31:0]       ld_wr_data_s;
  logic [3:0]        ld_wr_be_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [31:0]       ram_wdata_s;
  logic [3:0]        ram_be_s;
  logic [31:0]       i_data_r;
  logic [31:0]       d_data_r;
  logic              d_err_r;

  assign d_word_s = bus.d_addr[ADDR_W+1:2];
  assign d_off_s  = bus.d_addr[1:0];
  assign legal_s  = is_legal(bus.d_size, d_off_s);

  twitch_mem_loader #(
    .ADDR_W    (ADDR_W),
    .LOAD_BASE (LOAD_BASE)
  ) u_loader (
    .clk      (clk),
    .resetn   (resetn),
    .ld_start (bus.ld_start),
    .ld_valid (bus.ld_valid),
    .ld_byte  (bus.ld_byte),
    .ld_last  (bus.ld_last),
    .ld_ready (ld_ready_s),
    .ld_busy  (ld_busy_s),
    .wr_en    (ld_wr_en_s),
    .wr_addr  (ld_wr_addr_s),
    .wr_data  (ld_wr_data_s),
    .wr_be    (ld_wr_be_s)
  );

  // Write arbitration: loader first; core stores only when legal and no load session is active.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = d_word_s;
    ram_wdata_s = bus.d_wdata << {d_off_s, 3'b000};
    ram_be_s    = byte_en(bus.d_size, d_off_s);
    if (!resetn) begin
      ram_we_s = 1'b0;
    end else if (ld_wr_en_s) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = ld_wr_addr_s;
      ram_wdata_s = ld_wr_data_s;
      ram_be_s    = ld_wr_be_s;
    end else if (bus.d_we && legal_s && !ld_busy_s) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // RAM array with per-lane write enables; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be_s[b]) begin
          ram[ram_addr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Registered read ports and the per-cycle misalignment flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      i_data_r <= 32'd0;
      d_data_r <= 32'd0;
      d_err_r  <= 1'b0;
    end else begin
      i_data_r <= ram[bus.i_addr];
      d_data_r <= ram[d_word_s] >> {d_off_s, 3'b000};
      d_err_r  <= !legal_s;
    end
  end

  assign bus.i_data   = i_data_r;
  assign bus.d_data   = d_data_r;
  assign bus.d_err    = d_err_r;
  assign bus.ld_ready = ld_ready_s;
  assign bus.ld_busy  = ld_busy_s;

endmodule

// File: tb/tb_twitch_mem.sv
// Directed self-checking bench for twitch_mem: data port sizing/alignment,
// read-first behaviour, loader sessions, wrap-around and reset abort.
module tb_twitch_mem;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  twitch_mem_if #(.ADDR_W(12)) bus ();
  twitch_mem_if #(.ADDR_W(2))  bus2 ();

  twitch_mem #(.ADDR_W(12), .LOAD_BASE(0)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
  twitch_mem #(.ADDR_W(2),  .LOAD_BASE(3)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.i_addr = 12'd0;  bus.d_addr = 14'd0;  bus.d_size = 2'b10;
    bus.d_we = 1'b0;     bus.d_wdata = 32'd0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_byte = 8'd0; bus.ld_last = 1'b0;
    bus2.i_addr = 2'd0;  bus2.d_addr = 4'd0;  bus2.d_size = 2'b10;
    bus2.d_we = 1'b0;    bus2.d_wdata = 32'd0;
    bus2.ld_start = 1'b0; bus2.ld_valid = 1'b0; bus2.ld_byte = 8'd0; bus2.ld_last = 1'b0;
  endtask

  task automatic store(input logic [13:0] addr, input logic [1:0] size, input logic [31:0] data);
    bus.d_addr = addr; bus.d_size = size; bus.d_wdata = data; bus.d_we = 1'b1;
    cyc();
    bus.d_we = 1'b0; bus.d_addr = 14'd0; bus.d_size = 2'b10;
  endtask

  task automatic load(input logic [13:0] addr, input logic [1:0] size, output logic [31:0] got);
    bus.d_addr = addr; bus.d_size = size;
    cyc();
    got = bus.d_data;
    bus.d_addr = 14'd0; bus.d_size = 2'b10;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    while (bus.ld_ready !== 1'b1 && t < 20) begin
      cyc();
      t++;
    end
    n_tests++;
    if (bus.ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_ready_wait: got %b required 1 within 20 cycles", bus.ld_ready);
    end
    bus.ld_valid = 1'b1; bus.ld_byte = b; bus.ld_last = last;
    cyc();
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(); cyc();
    n_tests++;
    if ({bus.i_data, bus.d_data, bus.d_err, bus.ld_ready, bus.ld_busy} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_state: got i=%h d=%h err=%b rdy=%b busy=%b required all zero",
               bus.i_data, bus.d_data, bus.d_err, bus.ld_ready, bus.ld_busy);
    end
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_word();
    logic [31:0] got;
    store(14'h10, 2'b10, 32'hDEADBEEF);
    bus.i_addr = 12'd4;
    load(14'h10, 2'b10, got);
    n_tests++;
    if (got !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_load: got %h required DEADBEEF", got);
    end
    n_tests++;
    if (bus.i_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ifetch_word: got %h required DEADBEEF", bus.i_data);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] got;
    store(14'h10, 2'b10, 32'h0000_0000);
    store(14'h13, 2'b00, 32'h0000_00AB);
    load(14'h10, 2'b10, got);
    n_tests++;
    if (got !== 32'hAB000000) begin
      n_fail++; $display("FAIL byte_store_word_load: got %h required AB000000", got);
    end
    load(14'h13, 2'b00, got);
    n_tests++;
    if (got !== 32'h000000AB) begin
      n_fail++; $display("FAIL byte_load_off3: got %h required 000000AB", got);
    end
    load(14'h12, 2'b01, got);
    n_tests++;
    if (got !== 32'h0000AB00) begin
      n_fail++; $display("FAIL half_load_off2: got %h required 0000AB00", got);
    end
  endtask

  task automatic test_align();
    logic [31:0] got;
    bus.d_addr = 14'h11; bus.d_size = 2'b01; bus.d_wdata = 32'h0000FFFF; bus.d_we = 1'b1;
    cyc();
    bus.d_we = 1'b0; bus.d_addr = 14'd0; bus.d_size = 2'b10;
    n_tests++;
    if (bus.d_err !== 1'b1) begin
      n_fail++; $display("FAIL err_half_off1: got %b required 1", bus.d_err);
    end
    cyc();
    n_tests++;
    if (bus.d_err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: got %b required 0", bus.d_err);
    end
    load(14'h10, 2'b10, got);
    n_tests++;
    if (got !== 32'hAB000000) begin
      n_fail++; $display("FAIL misaligned_store_suppressed: got %h required AB000000", got);
    end
    bus.d_addr = 14'h10; bus.d_size = 2'b11; bus.d_wdata = 32'hFFFFFFFF; bus.d_we = 1'b1;
    cyc();
    bus.d_we = 1'b0; bus.d_size = 2'b10;
    n_tests++;
    if (bus.d_err !== 1'b1) begin
      n_fail++; $display("FAIL err_size11: got %b required 1", bus.d_err);
    end
    load(14'h10, 2'b10, got);
    n_tests++;
    if (got !== 32'hAB000000 || bus.d_err !== 1'b0) begin
      n_fail++; $display("FAIL size11_store_suppressed: got %h err=%b required AB000000 err=0", got, bus.d_err);
    end
  endtask

  task automatic test_read_first();
    bus.i_addr = 12'd4;
    bus.d_addr = 14'h10; bus.d_size = 2'b10; bus.d_wdata = 32'hCAFEF00D; bus.d_we = 1'b1;
    cyc();
    bus.d_we = 1'b0;
    n_tests++;
    if (bus.d_data !== 32'hAB000000 || bus.i_data !== 32'hAB000000) begin
      n_fail++; $display("FAIL read_first: got d=%h i=%h required AB000000", bus.d_data, bus.i_data);
    end
    cyc();
    n_tests++;
    if (bus.d_data !== 32'hCAFEF00D || bus.i_data !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL after_write: got d=%h i=%h required CAFEF00D", bus.d_data, bus.i_data);
    end
    bus.d_addr = 14'd0;
  endtask

  task automatic test_loader();
    logic [31:0] got;
    bus.ld_start = 1'b1;
    cyc();
    bus.ld_start = 1'b0;
    n_tests++;
    if (bus.ld_busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
      n_fail++; $display("FAIL ld_start: got busy=%b rdy=%b required 1 1", bus.ld_busy, bus.ld_ready);
    end
    send_byte(8'h78, 1'b0);
    cyc();
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    store(14'h10, 2'b10, 32'h55555555);
    send_byte(8'h12, 1'b0);
    send_byte(8'hEF, 1'b0);
    cyc(); cyc();
    send_byte(8'hBE, 1'b1);
    n_tests++;
    if (bus.ld_busy !== 1'b1 || bus.ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got busy=%b rdy=%b required 1 0", bus.ld_busy, bus.ld_ready);
    end
    cyc();
    n_tests++;
    if (bus.ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_fall: got %b required 0", bus.ld_busy);
    end
    load(14'h0, 2'b10, got);
    n_tests++;
    if (got !== 32'h12345678) begin
      n_fail++; $display("FAIL loader_word0: got %h required 12345678", got);
    end
    load(14'h4, 2'b10, got);
    n_tests++;
    if (got !== 32'h0000BEEF) begin
      n_fail++; $display("FAIL loader_partial: got %h required 0000BEEF", got);
    end
    load(14'h10, 2'b10, got);
    n_tests++;
    if (got !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL store_during_load: got %h required CAFEF00D", got);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    store(14'h0, 2'b10, 32'h11111111);
    bus.ld_start = 1'b1;
    cyc();
    bus.ld_start = 1'b0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    n_tests++;
    if (bus.ld_busy !== 1'b0 || bus.ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b rdy=%b required 0 0", bus.ld_busy, bus.ld_ready);
    end
    load(14'h0, 2'b10, got);
    n_tests++;
    if (got !== 32'h11111111) begin
      n_fail++; $display("FAIL abort_word_kept: got %h required 11111111", got);
    end
    bus.ld_start = 1'b1;
    cyc();
    bus.ld_start = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    n_tests++;
    if (bus.ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL full_word_last_busy: got %b required 0", bus.ld_busy);
    end
    load(14'h0, 2'b10, got);
    n_tests++;
    if (got !== 32'h04030201) begin
      n_fail++; $display("FAIL reload_after_abort: got %h required 04030201", got);
    end
  endtask

  task automatic test_wrap();
    bus2.ld_start = 1'b1;
    cyc();
    bus2.ld_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      n_tests++;
      if (bus2.ld_ready !== 1'b1) begin
        n_fail++; $display("FAIL wrap_ready_%0d: got %b required 1", i, bus2.ld_ready);
      end
      bus2.ld_valid = 1'b1; bus2.ld_byte = 8'(i); bus2.ld_last = (i == 8);
      cyc();
    end
    bus2.ld_valid = 1'b0; bus2.ld_last = 1'b0;
    n_tests++;
    if (bus2.ld_busy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_busy: got %b required 0", bus2.ld_busy);
    end
    bus2.d_addr = 4'hC; bus2.d_size = 2'b10; bus2.i_addr = 2'd0;
    cyc();
    n_tests++;
    if (bus2.d_data !== 32'h04030201) begin
      n_fail++; $display("FAIL wrap_word3: got %h required 04030201", bus2.d_data);
    end
    n_tests++;
    if (bus2.i_data !== 32'h08070605) begin
      n_fail++; $display("FAIL wrap_word0: got %h required 08070605", bus2.i_data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_bus();
    test_reset();
    test_word();
    test_byte_half();
    test_align();
    test_read_first();
    test_loader();
    test_reset_abort();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/twitch_mem.md
Name: twitch_mem

Overview:
- Memory responder on the far side of the core's instruction and data fetch interfaces.
- Single word-organised RAM with three ports:
  - an instruction read port;
  - a data load/store port with byte/half/word sizing and lane alignment;
  - a byte-stream program loader that fills RAM while the core is held off.
- Sits between the core and the top-level host/UART byte source.

Parameters:
- ADDR_W, 12, word-address width; RAM depth = 2**ADDR_W words of 32 bits.
- LOAD_BASE, 0, first word address written by the loader.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- i_addr  in  ADDR_W  instruction word address
- i_data  out  32  instruction word, registered
- d_addr  in  ADDR_W+2  data byte address; [1:0] is the byte offset
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_we  in  1  store strobe
- d_wdata  in  32  store data, right-aligned
- d_data  out  32  load data, right-aligned (shifted down by offset), registered
- d_err  out  1  misaligned/illegal access flag, registered
- ld_start  in  1  begin load session
- ld_valid  in  1  byte available
- ld_byte  in  8  stream byte, little-endian order
- ld_last  in  1  qualifies the final byte of the stream
- ld_ready  out  1  loader accepts byte this cycle
- ld_busy  out  1  load session in progress; top holds the core in reset

Behaviour:
- Reset values: i_data=0, d_data=0, d_err=0, ld_ready=0, ld_busy=0, FSM=IDLE, counters cleared. RAM contents are not reset.
- Instruction port: i_data <= ram[i_addr] every cycle; latency 1.
- Data load: d_data <= ram[d_addr[ADDR_W+1:2]] >> (8*d_addr[1:0]); latency 1; upper bits zero. Sign extension is the core's job.
- Alignment:
  - Legal: byte at any offset; half at offset 0 or 2; word at offset 0.
  - Otherwise, and always for d_size=11: d_err=1 on the next cycle and the store is suppressed. Read data is still returned.
  - d_err is a one-cycle pulse per offending cycle.
- Store (d_we=1, legal, FSM=IDLE):
  - Byte enables: byte 0001<<off; half 0011<<off; word 1111.
  - Lane data: d_wdata << (8*off).
  - Only enabled lanes are written.
- Read-during-write, same word, either port: returns the old word (read-first).
- Loader FSM, states IDLE, COLLECT, FLUSH:
  - IDLE:
    - ld_start=1 -> COLLECT; waddr<=LOAD_BASE, bcnt<=0, shift reg<=0, ld_busy<=1.
    - Data-port stores are ignored while ld_busy=1.
  - COLLECT:
    - ld_ready=1. A byte transfers on ld_valid&&ld_ready into lane bcnt.
    - bcnt==3 on transfer: write the full word at waddr in the same cycle; waddr++ (wraps mod 2**ADDR_W); bcnt<=0.
    - ld_last on transfer:
      - if bcnt==3, word written as above, -> IDLE;
      - else -> FLUSH.
  - FLUSH:
    - ld_ready=0. Write the partial word with unfilled lanes zero; -> IDLE.
  - Returning to IDLE: ld_busy<=0 the cycle after the final write.
  - ld_start while not in IDLE: ignored.
- Loader write and data store in the same cycle: the loader wins (data store is already ignored while busy).
- resetn low mid-load: FSM aborts to IDLE. Already-written words persist; the partial word is discarded.

Decomposition:
- Shared package:
  - size encodings (SZ_B, SZ_H, SZ_W);
  - loader state enum;
  - function computing the byte-enable mask from size and offset;
  - function for the legality check.
- One sub-module, twitch_mem_loader: FSM, byte assembly, address counter. It outputs a write request (addr, data, 4-bit be) to the RAM owner in twitch_mem.

Test Plan:
- Word store 0xDEADBEEF at byte addr 0x10, then load word at 0x10 -> d_data=0xDEADBEEF one cycle after the load; i_addr=4 -> i_data=0xDEADBEEF.
- Byte store 0xAB at 0x13 over 0x00000000, then word load at 0x10 -> 0xAB000000; byte load at 0x13 -> 0x000000AB; half load at 0x12 -> 0x0000AB00.
- Half store at 0x11 -> d_err=1 for one cycle, word at 0x10 unchanged; d_size=11 at 0x10 -> d_err=1.
- Loader: ld_start, then bytes 78 56 34 12 EF BE (ld_last on 0xBE) with ld_valid gaps -> ram[0]=0x12345678, ram[1]=0x0000BEEF, ld_busy falls after the FLUSH write; a store issued mid-load has no effect.
- Loader with ADDR_W=2, LOAD_BASE=3, 8 bytes -> writes word 3 then wraps to word 0.
- resetn=0 after 2 of 4 bytes -> ld_busy=0, FSM IDLE, target word unchanged; a fresh ld_start loads normally.
